hex_display_scanner: RTL and testbench

Time-multiplexed hexadecimal display driver for the processor debug path: shows any DATA_W-bit value (PC, ALU result, register read-out) on DIGITS shared-segment 7-segment digits. Successor to the static 4-display PC viewer: parametrised width and digit count, anode scanning, manual or auto-cycling page selection, and a hold/freeze capture. Sits between the datapath debug taps and the board display pins.

---
 rtl/hex_display_scanner_pkg.sv | 32 +++
 rtl/hex_display_scanner_hex_to_7seg.sv | 37 +++
 rtl/hex_display_scanner.sv | 126 ++++++++++++
 tb/tb_hex_display_scanner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hex_display_scanner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_display_scanner_pkg : shared constants and sizing helpers        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hex_display_scanner_pkg;

  // Bit positions inside the {g,f,e,d,c,b,a} segment vector
  localparam int c_SEG_A = 0;
  localparam int c_SEG_B = 1;
  localparam int c_SEG_C = 2;
  localparam int c_SEG_D = 3;
  localparam int c_SEG_E = 4;
  localparam int c_SEG_F = 5;
  localparam int c_SEG_G = 6;

  localparam logic [6:0] c_SEG_BLANK = 7'h00;

  function automatic int hds_min_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int hds_pages(input int data_w, input int digits);
    return data_w / (4 * digits);
  endfunction

  function automatic int hds_page_w(input int data_w, input int digits);
    return hds_min_w(hds_pages(data_w, digits));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_display_scanner_hex_to_7seg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_to_7seg : 4-bit hex nibble to active-high {g,f,e,d,c,b,a}         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hex_to_7seg
  import hex_display_scanner_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = c_SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = 7'h3F;
      4'h1: o_seg = 7'h06;
      4'h2: o_seg = 7'h5B;
      4'h3: o_seg = 7'h4F;
      4'h4: o_seg = 7'h66;
      4'h5: o_seg = 7'h6D;
      4'h6: o_seg = 7'h7D;
      4'h7: o_seg = 7'h07;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h6F;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h7C;
      4'hC: o_seg = 7'h39;
      4'hD: o_seg = 7'h5E;
      4'hE: o_seg = 7'h79;
      4'hF: o_seg = 7'h71;
      default: o_seg = c_SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hex_display_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_display_scanner : time-multiplexed paged hex display driver      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int PAGE_DIV   = 256,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_W-1:0]                      data,
  input  logic                                   hold,
  input  logic                                   mode,
  input  logic [hds_page_w(DATA_W, DIGITS)-1:0]  page_sel,
  output logic [6:0]                             seg,
  output logic [DIGITS-1:0]                      an,
  output logic                                   dp,
  output logic [hds_page_w(DATA_W, DIGITS)-1:0]  page_out
);

  localparam int c_PAGES  = hds_pages(DATA_W, DIGITS);
  localparam int c_PAGE_W = hds_page_w(DATA_W, DIGITS);
  localparam int c_DIG_W  = hds_min_w(DIGITS);
  localparam int c_DIV_W  = hds_min_w(SCAN_DIV);
  localparam int c_FRM_W  = hds_min_w(PAGE_DIV);

  logic [DATA_W-1:0]   r_shadow;
  logic [c_DIV_W-1:0]  r_div;
  logic [c_DIG_W-1:0]  r_digit;
  logic [c_FRM_W-1:0]  r_frame;
  logic [c_PAGE_W-1:0] r_page;
  logic                r_auto;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_an;
  logic                r_dp;

  logic                w_div_tc;
  logic                w_last_digit;
  logic                w_frame_end;
  logic [c_PAGE_W-1:0] w_page_man;
  logic [c_PAGE_W-1:0] w_page_inc;
  int                  w_bit;
  logic [3:0]          w_nibble;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_an;
  logic                w_dp;

  assign w_div_tc     = (r_div == c_DIV_W'(SCAN_DIV - 1));
  assign w_last_digit = (r_digit == c_DIG_W'(DIGITS - 1));
  assign w_frame_end  = w_div_tc && w_last_digit;

  assign w_page_man = (32'(page_sel) >= 32'(c_PAGES)) ? '0 : page_sel;
  assign w_page_inc = (r_page == c_PAGE_W'(c_PAGES - 1)) ? '0
                                                         : r_page + c_PAGE_W'(1);

  // Digit 0 is the leftmost digit and carries the page's top nibble
  assign w_bit    = int'(r_page) * 4 * DIGITS + 4 * (DIGITS - 1 - int'(r_digit));
  assign w_nibble = r_shadow[w_bit +: 4];
  assign w_an     = DIGITS'(1) << r_digit;
  assign w_dp     = (int'(r_digit) == int'(r_page));

  hex_to_7seg u_hex_to_7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_div    <= '0;
      r_digit  <= '0;
      r_frame  <= '0;
      r_page   <= '0;
      r_auto   <= 1'b0;
      r_seg    <= c_SEG_BLANK ^ {7{ACTIVE_LOW}};
      r_an     <= {DIGITS{ACTIVE_LOW}};
      r_dp     <= ACTIVE_LOW;
    end else begin
      if (!hold) begin
        r_shadow <= data;
      end

      if (w_div_tc) begin
        r_div   <= '0;
        r_digit <= w_last_digit ? '0 : r_digit + c_DIG_W'(1);
      end else begin
        r_div <= r_div + c_DIV_W'(1);
      end

      // Page only moves between frames; r_auto is the mode of the frame just shown
      if (w_frame_end) begin
        r_auto <= mode;
        if (r_auto && mode) begin
          if (r_frame == c_FRM_W'(PAGE_DIV - 1)) begin
            r_frame <= '0;
            r_page  <= w_page_inc;
          end else begin
            r_frame <= r_frame + c_FRM_W'(1);
          end
        end else if (mode) begin
          r_frame <= '0;
        end else begin
          r_frame <= '0;
          r_page  <= w_page_man;
        end
      end

      r_seg <= w_seg ^ {7{ACTIVE_LOW}};
      r_an  <= w_an ^ {DIGITS{ACTIVE_LOW}};
      r_dp  <= w_dp ^ ACTIVE_LOW;
    end
  end

  assign seg      = r_seg;
  assign an       = r_an;
  assign dp       = r_dp;
  assign page_out = r_page;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hex_display_scanner : directed bench, two parameter sets          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hex_display_scanner;

  localparam logic [6:0] S0 = 7'h3F;
  localparam logic [6:0] S1 = 7'h06;
  localparam logic [6:0] S2 = 7'h5B;
  localparam logic [6:0] S3 = 7'h4F;
  localparam logic [6:0] S4 = 7'h66;
  localparam logic [6:0] SA = 7'h77;
  localparam logic [6:0] SB = 7'h7C;
  localparam logic [6:0] SC = 7'h39;
  localparam logic [6:0] SD = 7'h5E;
  localparam logic [6:0] SF = 7'h71;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        hold;
  logic        mode;
  logic [0:0]  page_sel;

  logic [6:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;
  logic        dp_a, dp_b;
  logic [0:0]  pg_a, pg_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .DATA_W(32), .DIGITS(4), .SCAN_DIV(2), .PAGE_DIV(1), .ACTIVE_LOW(1'b0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .data(data), .hold(hold), .mode(mode),
    .page_sel(page_sel), .seg(seg_a), .an(an_a), .dp(dp_a), .page_out(pg_a)
  );

  hex_display_scanner #(
    .DATA_W(32), .DIGITS(4), .SCAN_DIV(1), .PAGE_DIV(1), .ACTIVE_LOW(1'b1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .data(data), .hold(hold), .mode(mode),
    .page_sel(page_sel), .seg(seg_b), .an(an_b), .dp(dp_b), .page_out(pg_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [6:0] s, input logic [3:0] a,
                       input logic d, input logic p);
    n_assert++;
    assert (seg_a === s) else begin
      n_fail++; $error("FAIL %s A.seg got %h exp %h", tag, seg_a, s);
    end
    n_assert++;
    assert (an_a === a) else begin
      n_fail++; $error("FAIL %s A.an got %b exp %b", tag, an_a, a);
    end
    n_assert++;
    assert (dp_a === d) else begin
      n_fail++; $error("FAIL %s A.dp got %b exp %b", tag, dp_a, d);
    end
    n_assert++;
    assert (pg_a === p) else begin
      n_fail++; $error("FAIL %s A.page got %0d exp %0d", tag, pg_a, p);
    end
  endtask

  task automatic chk_b(input string tag, input logic [6:0] s, input logic [3:0] a,
                       input logic d, input logic p);
    n_assert++;
    assert (seg_b === s) else begin
      n_fail++; $error("FAIL %s B.seg got %h exp %h", tag, seg_b, s);
    end
    n_assert++;
    assert (an_b === a) else begin
      n_fail++; $error("FAIL %s B.an got %b exp %b", tag, an_b, a);
    end
    n_assert++;
    assert (dp_b === d) else begin
      n_fail++; $error("FAIL %s B.dp got %b exp %b", tag, dp_b, d);
    end
    n_assert++;
    assert (pg_b === p) else begin
      n_fail++; $error("FAIL %s B.page got %0d exp %0d", tag, pg_b, p);
    end
  endtask

  // k below is the number of clock edges since the last reset edge
  initial begin
    rst = 1'b1; data = '0; hold = 1'b0; mode = 1'b0; page_sel = 1'b0;
    tick(2);
    chk_a("reset", 7'h00, 4'b0000, 1'b0, 1'b0);
    chk_b("reset", 7'h7F, 4'b1111, 1'b1, 1'b0);
    rst = 1'b0; data = 32'h1234ABCD;

    tick(1); // k=1: shadow still zero when digit 0 was decoded
    chk_a("k1_zero", S0, 4'b0001, 1'b1, 1'b0);
    chk_b("k1_zero", ~S0, 4'b1110, 1'b0, 1'b0);
    tick(1); // k=2
    chk_a("k2_dig0", SA, 4'b0001, 1'b1, 1'b0);
    chk_b("k2_dig1", ~SB, 4'b1101, 1'b1, 1'b0);
    tick(1); // k=3
    chk_a("k3_dig1", SB, 4'b0010, 1'b0, 1'b0);
    chk_b("k3_dig2", ~SC, 4'b1011, 1'b1, 1'b0);
    tick(1); // k=4
    chk_a("k4_dig1", SB, 4'b0010, 1'b0, 1'b0);
    chk_b("k4_dig3", ~SD, 4'b0111, 1'b1, 1'b0);
    tick(1); // k=5
    chk_a("k5_dig2", SC, 4'b0100, 1'b0, 1'b0);
    chk_b("k5_wrap", ~SA, 4'b1110, 1'b0, 1'b0);
    tick(2); // k=7
    chk_a("k7_dig3", SD, 4'b1000, 1'b0, 1'b0);
    tick(2); // k=9
    chk_a("k9_wrap", SA, 4'b0001, 1'b1, 1'b0);

    tick(1); // k=10
    page_sel = 1'b1;
    tick(1); // k=11: page held until frame boundary
    chk_a("k11_noTear", SB, 4'b0010, 1'b0, 1'b0);
    tick(5); // k=16
    chk_a("k16_pgswap", SD, 4'b1000, 1'b0, 1'b1);
    tick(1); // k=17
    chk_a("k17_p1d0", S1, 4'b0001, 1'b0, 1'b1);
    tick(1); // k=18
    mode = 1'b1;
    tick(1); // k=19
    chk_a("k19_p1d1", S2, 4'b0010, 1'b1, 1'b1);
    tick(2); // k=21
    chk_a("k21_p1d2", S3, 4'b0100, 1'b0, 1'b1);
    tick(2); // k=23
    chk_a("k23_p1d3", S4, 4'b1000, 1'b0, 1'b1);

    tick(8); // k=31: auto entered at k=24 keeping page 1
    chk_a("k31_auto", S4, 4'b1000, 1'b0, 1'b1);
    tick(2); // k=33
    chk_a("k33_auto0", SA, 4'b0001, 1'b1, 1'b0);
    tick(6); // k=39
    chk_a("k39_auto0", SD, 4'b1000, 1'b0, 1'b0);
    tick(2); // k=41
    chk_a("k41_auto1", S1, 4'b0001, 1'b0, 1'b1);
    mode = 1'b0; page_sel = 1'b0;

    tick(1); // k=42
    hold = 1'b1;
    tick(1); // k=43
    data = 32'hFFFFFFFF;
    tick(6); // k=49
    chk_a("k49_hold", SA, 4'b0001, 1'b1, 1'b0);
    tick(2); // k=51
    chk_a("k51_hold", SB, 4'b0010, 1'b0, 1'b0);
    tick(1); // k=52
    chk_a("k52_hold", SB, 4'b0010, 1'b0, 1'b0);
    hold = 1'b0;
    tick(1); // k=53
    chk_a("k53_lat1", SC, 4'b0100, 1'b0, 1'b0);
    tick(1); // k=54
    chk_a("k54_lat2", SF, 4'b0100, 1'b0, 1'b0);

    tick(6); // k=60: mid digit 2
    rst = 1'b1;
    tick(1);
    chk_a("rst_mid", 7'h00, 4'b0000, 1'b0, 1'b0);
    chk_b("rst_mid", 7'h7F, 4'b1111, 1'b1, 1'b0);
    rst = 1'b0;
    tick(1);
    chk_a("rel_k1", S0, 4'b0001, 1'b1, 1'b0);
    tick(1);
    chk_a("rel_k2", SF, 4'b0001, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
